// File: rtl/mac_unit_if.sv
// Operand/result handshake bundle for mac_unit.
// The master drives operands and control, and the slave (mac_unit) returns status and result.
interface mac_unit_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic                     start;
    logic [LEN_W-1:0]         len;
    logic                     abort;
    logic signed [DATA_W-1:0] aIn;
    logic signed [DATA_W-1:0] bIn;
    logic                     inValid;
    logic                     inReady;
    logic [7:0]               resOut;
    logic                     resValid;
    logic                     busy;

    modport master (
        output start, len, abort, aIn, bIn, inValid,
        input  inReady, resOut, resValid, busy
    );

    modport slave (
        input  start, len, abort, aIn, bIn, inValid,
        output inReady, resOut, resValid, busy
    );
endinterface

// File: rtl/mac_unit.sv
// Multiply-accumulate over a programmed number of signed operand pairs.
// The sum is rescaled, clamped to 0..255 and strobed out for one cycle.
module mac_unit #(
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 4,
    parameter int ACC_W     = 20,
    parameter int OUT_SHIFT = 0
) (
    input  logic      clk,
    input  logic      rst,
    mac_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic signed [ACC_W-1:0] MAX_OUT = ACC_W'(255);

    state_t                  state_reg, state_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next, acc_sum;
    logic [LEN_W-1:0]        cnt_reg, cnt_next;
    logic [LEN_W-1:0]        len_reg, len_next;
    logic [7:0]              res_reg, res_next;
    logic signed [2*DATA_W-1:0] prod;
    logic                    last_pair;
    logic                    in_ready, res_valid, busy;

    function automatic logic [7:0] clamp8(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> OUT_SHIFT;
        if (s[ACC_W-1])
            return 8'd0;
        else if (s > MAX_OUT)
            return 8'd255;
        else
            return s[7:0];
    endfunction

    assign prod      = $signed(bus.aIn) * $signed(bus.bIn);
    assign acc_sum   = acc_reg + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign last_pair = (cnt_reg == len_reg - LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
            res_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
            res_reg   <= res_next;
        end
    end

    // The result register is loaded on the final accepted pair so it is
    // already stable during the single OUT cycle.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        res_next   = res_reg;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.abort && (bus.len != '0)) begin
                    len_next   = bus.len;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (bus.abort) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (bus.inValid) begin
                    acc_next = acc_sum;
                    cnt_next = cnt_reg + LEN_W'(1);
                    if (last_pair) begin
                        res_next   = clamp8(acc_sum);
                        state_next = OUT;
                    end
                end
            end
            OUT: begin
                busy       = 1'b1;
                res_valid  = !bus.abort;
                state_next = IDLE;
                if (bus.abort) begin
                    acc_next = '0;
                    cnt_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.inReady  = in_ready;
    assign bus.resValid = res_valid;
    assign bus.busy     = busy;
    assign bus.resOut   = res_reg;
endmodule

// File: doc/mac_unit.md
Name: mac_unit

Overview:
Multiply-accumulate stage feeding the 4-entry result buffer of the compute datapath. It consumes a stream of signed 8-bit operand pairs (window × filter) for a programmed length and accumulates their products at full precision. It then rescales and clamps the sum to an unsigned 8-bit result and pulses it out for one cycle. resValid/resOut connect directly to the result buffer's en/valIn.

Parameters:
DATA_W, 8, operand width (signed two's complement)
LEN_W, 4, width of the length field; max pairs per operation = 2^LEN_W-1
ACC_W, 20, accumulator width; must be >= 2*DATA_W+LEN_W
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before clamping

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  begin operation; sampled only in IDLE
len  in  LEN_W  number of operand pairs; latched on accepted start
abort  in  1  synchronous cancel of the current operation
aIn  in  DATA_W  signed operand A
bIn  in  DATA_W  signed operand B
inValid  in  1  aIn/bIn valid this cycle
inReady  out  1  block accepts a pair this cycle (high only in ACC)
resOut  out  8  clamped unsigned result
resValid  out  1  one-cycle result strobe
busy  out  1  high in ACC and OUT

Behaviour:
- Reset (async): state=IDLE, acc=0, cnt=0, lenReg=0; inReady=0, resValid=0, resOut=0, busy=0.
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - start=1 and len!=0: lenReg<=len, acc<=0, cnt<=0, go ACC.
  - start=1 and len==0: ignored, stay IDLE, no result.
- ACC:
  - inReady=1.
  - Pair accepted when inValid=1: acc <= acc + sext(aIn*bIn), signed 2*DATA_W product sign-extended to ACC_W; cnt<=cnt+1.
  - When the accepted pair is pair number lenReg (cnt==lenReg-1), go OUT.
  - inValid=0: hold acc and cnt; no timeout.
- OUT (exactly one cycle):
  - resValid=1, resOut=clamp(acc>>>OUT_SHIFT), inReady=0.
  - Then go IDLE.
  - Latency: resValid is asserted on the cycle after the last pair is accepted.
- Clamp: s=acc>>>OUT_SHIFT (signed); s<0 -> 0; s>255 -> 255; else s[7:0].
- resOut is registered and holds its last value after OUT. resValid is 0 outside OUT.
- start outside IDLE is ignored; len changes outside IDLE have no effect.
- abort:
  - In ACC or OUT: next state IDLE, acc<=0, cnt<=0, resValid forced 0 that cycle.
  - abort has priority over pair acceptance and over start.
  - abort in IDLE: no effect, and start is ignored that cycle.
- Back-to-back: start may be asserted in the IDLE cycle right after OUT. Minimum spacing between results is len+2 cycles.
- No overflow is possible with ACC_W >= 2*DATA_W+LEN_W; this is a parameter constraint, not checked at runtime.
- rst mid-operation: immediate return to the reset state; no resValid is produced for the interrupted operation.

Test Plan:
1. len=4; pairs (1,1),(2,1),(3,1),(4,1) with continuous inValid -> inReady high for 4 cycles; resValid=1 for exactly 1 cycle, 1 cycle after the 4th pair; resOut=10; busy falls afterwards.
2. Same operands with inValid low for 2 cycles between pairs 2 and 3 -> acc holds during the gaps; resOut=10; resValid exactly 1 cycle after the 4th accepted pair.
3. Clamping:
   - len=2, pairs (100,100),(100,100) -> acc=20000, resOut=255.
   - len=1, pair (-5,3) -> resOut=0.
   - len=3, pairs (-128,-128),(-128,127),(1,1) -> acc=129, resOut=129.
4. Abort after 2 of 4 pairs -> back to IDLE, no resValid. Then start len=1, pair (7,6) -> resOut=42 (no residue from the aborted operation).
5. Edge conditions:
   - start with len=0 -> stays IDLE, busy=0.
   - start during ACC -> ignored.
   - rst asserted mid-ACC -> all outputs 0 immediately; no spurious resValid.
   - Two back-to-back len=1 operations -> two strobes 3 cycles apart.
6. OUT_SHIFT=4, len=1, pair (16,16) -> resOut=16. Drive 4 consecutive results into the result buffer -> buffer full asserts after the 4th strobe.
